ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter: sends one command byte from the host to the keyboard, for example 0xED (set LEDs) or 0xFF (reset). It uses the PS/2 request-to-send sequence, odd parity, and checks the device acknowledge bit. It sits beside `kbd_intf` on the shared PS2_Clk/PS2_Data open-collector pins; `kbd_intf` is the device-to-host receiver. While this block runs, it holds the receiver off.

---
 rtl/ps2_host_tx.sv | 181 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: RTS, odd parity, ACK check, whole-transfer timeout; tx_start ignored while busy.
// `define PS2TX_RETRY_EN resends the latched byte up to twice on NACK/timeout before reporting.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 375000
) (
  input  logic       clk25,
  input  logic       reset_in,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       tx_err,
  output logic       rx_hold
);
  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_SEND, S_ACK, S_WAITIDLE, S_DONE
  } state_t;

  localparam logic [11:0] INH_LAST = 12'(INHIBIT_CYCLES - 1);
  localparam logic [18:0] TO_LAST  = 19'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [1:0]  clk_sync;
  logic [1:0]  data_sync;
  logic        clk_prev;
  logic        fall;
  logic [7:0]  data_q;
  logic        parity;
  logic        nack;
  logic [3:0]  fall_cnt;
  logic [11:0] inh_cnt;
  logic [18:0] to_cnt;
  logic        timed;
  logic        timeout;
  logic        retry_ok;
  logic        frame_bit;

`ifdef PS2TX_RETRY_EN
  logic [1:0]  attempt;
  assign retry_ok = (attempt != 2'd2);
`else
  assign retry_ok = 1'b0;
`endif

  always_ff @(posedge clk25 or posedge reset_in) begin
    if (reset_in) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_i};
      data_sync <= {data_sync[0], ps2_data_i};
      clk_prev  <= clk_sync[1];
    end
  end

  assign fall    = clk_prev & ~clk_sync[1];
  assign timed   = (state == S_RTS) || (state == S_SEND) || (state == S_ACK) || (state == S_WAITIDLE);
  assign timeout = (to_cnt >= TO_LAST);
  assign rx_hold = busy;

  // fall_cnt holds the number of falls already seen, so it indexes the bit for the next fall
  always_comb begin
    frame_bit = 1'b1;
    if (fall_cnt < 4'd8)       frame_bit = data_q[fall_cnt[2:0]];
    else if (fall_cnt == 4'd8) frame_bit = parity;
  end

  always_ff @(posedge clk25 or posedge reset_in) begin
    if (reset_in) begin
      state       <= S_IDLE;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      tx_err      <= 1'b0;
      data_q      <= 8'h00;
      parity      <= 1'b0;
      nack        <= 1'b0;
      fall_cnt    <= 4'd0;
      inh_cnt     <= 12'd0;
      to_cnt      <= 19'd0;
`ifdef PS2TX_RETRY_EN
      attempt     <= 2'd0;
`endif
    end else begin
      done <= 1'b0;
      if (timed && to_cnt != '1) to_cnt <= to_cnt + 19'd1;

      if (timed && timeout) begin
        ps2_data_oe <= 1'b0;
        if (retry_ok) begin
          state      <= S_INHIBIT;
          ps2_clk_oe <= 1'b1;
          inh_cnt    <= 12'd0;
          nack       <= 1'b0;
`ifdef PS2TX_RETRY_EN
          attempt    <= attempt + 2'd1;
`endif
        end else begin
          state      <= S_DONE;
          ps2_clk_oe <= 1'b0;
          done       <= 1'b1;
          busy       <= 1'b0;
          tx_err     <= 1'b1;
        end
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            state <= S_IDLE;
            if (tx_start) begin
              state      <= S_INHIBIT;
              data_q     <= tx_data;
              parity     <= ~^tx_data;
              tx_err     <= 1'b0;
              nack       <= 1'b0;
              busy       <= 1'b1;
              ps2_clk_oe <= 1'b1;
              inh_cnt    <= 12'd0;
`ifdef PS2TX_RETRY_EN
              attempt    <= 2'd0;
`endif
            end
          end
          S_INHIBIT: begin
            if (inh_cnt >= INH_LAST) begin
              state       <= S_RTS;
              ps2_data_oe <= 1'b1;
              to_cnt      <= 19'd0;
            end else begin
              inh_cnt <= inh_cnt + 12'd1;
            end
          end
          S_RTS: begin
            state      <= S_SEND;
            ps2_clk_oe <= 1'b0;
            fall_cnt   <= 4'd0;
          end
          S_SEND: begin
            if (fall) begin
              fall_cnt    <= fall_cnt + 4'd1;
              ps2_data_oe <= ~frame_bit;
              if (fall_cnt == 4'd9) state <= S_ACK;
            end
          end
          S_ACK: begin
            if (fall) begin
              nack     <= data_sync[1];
              fall_cnt <= fall_cnt + 4'd1;
              state    <= S_WAITIDLE;
            end
          end
          S_WAITIDLE: begin
            if (clk_sync[1] && data_sync[1]) begin
              if (nack && retry_ok) begin
                state      <= S_INHIBIT;
                ps2_clk_oe <= 1'b1;
                inh_cnt    <= 12'd0;
                nack       <= 1'b0;
`ifdef PS2TX_RETRY_EN
                attempt    <= attempt + 2'd1;
`endif
              end else begin
                state  <= S_DONE;
                done   <= 1'b1;
                busy   <= 1'b0;
                tx_err <= nack;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device on open-collector lines plus a frame/parity reference model.
module tb_ps2_host_tx;
  localparam int INH  = 40;
  localparam int TO   = 2000;
  localparam int HALF = 20;
`ifdef PS2TX_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic       clk25 = 1'b0;
  logic       reset_in = 1'b1;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       ps2_clk_i, ps2_data_i, ps2_clk_oe, ps2_data_oe;
  logic       busy, done, tx_err, rx_hold;

  int n_assert = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int inh_phases = 0;
  logic clk_oe_q = 1'b0;

  assign ps2_clk_i  = ~ps2_clk_oe & ~dev_clk_low;
  assign ps2_data_i = ~ps2_data_oe & ~dev_data_low;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk25(clk25), .reset_in(reset_in), .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .tx_data(tx_data), .tx_start(tx_start),
    .busy(busy), .done(done), .tx_err(tx_err), .rx_hold(rx_hold)
  );

  always #5 clk25 = ~clk25;

  always @(negedge clk25) begin
    if (done === 1'b1) done_cnt++;
    if (ps2_clk_oe === 1'b1 && clk_oe_q === 1'b0) inh_phases++;
    clk_oe_q = ps2_clk_oe;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, observed hang expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk25);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // start bit, 8 data bits LSB first, odd parity, stop bit -- in the order the device samples them
  function automatic logic [10:0] exp_frame(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, (ones % 2 == 0), b, 1'b0};
  endfunction

  task automatic start_tx(input logic [7:0] b);
    tx_data  = b;
    tx_start = 1'b1;
    tick(1);
    tx_start = 1'b0;
  endtask

  // Device side: waits for RTS, clocks 11 bits sampling in the high phase, ACKs (or not) before fall 11.
  task automatic device(input bit nack, input bit poke, input bit abort, output logic [10:0] frame);
    int budget = 0;
    frame = '0;
    while (!(ps2_clk_i === 1'b1 && ps2_data_i === 1'b0) && budget < INH + 50) begin
      tick(1);
      budget++;
    end
    chk("rts_seen", 32'(ps2_clk_i === 1'b1 && ps2_data_i === 1'b0), 32'd1);
    for (int k = 0; k < 11; k++) begin
      if (poke && k == 4) begin
        tx_data  = 8'h55;
        tx_start = 1'b1;
        tick(1);
        tx_start = 1'b0;
        tick(HALF - 1);
      end else begin
        tick(HALF);
      end
      frame[k] = ps2_data_i;
      chk("busy_in_frame", 32'(busy), 32'd1);
      if (k == 10) begin
        dev_data_low = ~nack;
        tick(5);
      end
      dev_clk_low = 1'b1;
      tick(HALF);
      if (abort && k == 4) return;
      dev_clk_low = 1'b0;
    end
    dev_data_low = 1'b0;
  endtask

  task automatic run_xfer(input logic [7:0] b, input bit nack, input bit poke);
    logic [10:0] fr;
    int d0, i0, n;
    d0 = done_cnt;
    i0 = inh_phases;
    start_tx(b);
    chk("accept_clk_oe", 32'(ps2_clk_oe), 32'd1);
    chk("accept_busy", 32'(busy), 32'd1);
    chk("accept_rx_hold", 32'(rx_hold), 32'd1);
    chk("accept_tx_err_clear", 32'(tx_err), 32'd0);
    n = 0;
    while (ps2_data_oe !== 1'b1 && n < INH + 10) begin
      tick(1);
      n++;
    end
    chk("inhibit_len", 32'(n), 32'(INH));
    chk("rts_clk_oe", 32'(ps2_clk_oe), 32'd1);
    tick(1);
    chk("send_clk_released", 32'(ps2_clk_oe), 32'd0);
    chk("send_start_bit", 32'(ps2_data_oe), 32'd1);
    for (int a = 0; a < (nack ? ATTEMPTS : 1); a++) begin
      device(nack, poke && a == 0, 1'b0, fr);
      chk("frame", 32'(fr), 32'(exp_frame(b)));
    end
    n = 0;
    while (done_cnt == d0 && n < 200) begin
      tick(1);
      n++;
    end
    chk("done_seen", 32'(done_cnt != d0), 32'd1);
    chk("tx_err", 32'(tx_err), 32'(nack));
    chk("busy_after_done", 32'(busy), 32'd0);
    tick(20);
    chk("done_count", 32'(done_cnt - d0), 32'd1);
    chk("inhibit_phases", 32'(inh_phases - i0), 32'(nack ? ATTEMPTS : 1));
  endtask

  initial begin
    logic [10:0] fr;
    int n, d0, i0;
    logic [7:0] b;
    bit nk;

    tick(2);
    chk("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("rst_data_oe", 32'(ps2_data_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_tx_err", 32'(tx_err), 32'd0);
    chk("rst_rx_hold", 32'(rx_hold), 32'd0);
    reset_in = 1'b0;
    tick(3);

    run_xfer(8'hED, 1'b0, 1'b0);
    run_xfer(8'h01, 1'b0, 1'b0);
    run_xfer(8'h00, 1'b0, 1'b0);
    run_xfer(8'hED, 1'b1, 1'b0);
    run_xfer(8'hED, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      b  = 8'($urandom_range(0, 255));
      nk = ($urandom_range(0, 3) == 0);
      run_xfer(b, nk, 1'b0);
    end

    // device never clocks: timeout
    d0 = done_cnt;
    i0 = inh_phases;
    start_tx(8'hF4);
    n = 0;
    while (ps2_data_oe !== 1'b1 && n < INH + 10) begin
      tick(1);
      n++;
    end
    chk("to_inhibit_len", 32'(n), 32'(INH));
    n = 0;
    while (done !== 1'b1 && n < ATTEMPTS * (TO + INH + 10)) begin
      tick(1);
      n++;
    end
`ifndef PS2TX_RETRY_EN
    chk("timeout_len", 32'(n), 32'(TO));
`endif
    chk("to_done", 32'(done), 32'd1);
    chk("to_tx_err", 32'(tx_err), 32'd1);
    chk("to_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("to_data_oe", 32'(ps2_data_oe), 32'd0);
    tick(5);
    chk("to_done_count", 32'(done_cnt - d0), 32'd1);
    chk("to_inhibit_phases", 32'(inh_phases - i0), 32'(ATTEMPTS));

    // reset after fall 5 of 0xED (bit4 = 0, so data is being driven low)
    start_tx(8'hED);
    device(1'b0, 1'b0, 1'b1, fr);
    chk("mid_data_oe", 32'(ps2_data_oe), 32'd1);
    chk("mid_busy", 32'(busy), 32'd1);
    reset_in = 1'b1;
    #2;
    chk("arst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("arst_data_oe", 32'(ps2_data_oe), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_rx_hold", 32'(rx_hold), 32'd0);
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    tick(3);
    reset_in = 1'b0;
    tick(3);
    chk("post_rst_busy", 32'(busy), 32'd0);
    run_xfer(8'hFF, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
